// File: rtl/comparator_operand_serializer.sv
// rtl/comparator_operand_serializer.sv - operand serializer feeding a bit-serial unsigned comparator
//
// Purpose:
//   Accepts an unsigned operand pair (in_a, in_b) over a valid/ready handshake.
//   Clears the downstream sequential comparator with a one-cycle ser_rst pulse.
//   Shifts both operands out MSB-first, one bit pair per cycle.
//   Idles the serial lines for FLUSH cycles so the comparator pipeline can settle.
//   Drops ser_op to let the comparator display its L/E/G flags.
//
// Parameters:
//   W      operand width in bits (>= 1)
//   FLUSH  idle bit-cycles after the last bit (>= 1)
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      operand pair offered
//   in_ready      block can accept an operand pair (IDLE only)
//   in_a, in_b    W-bit unsigned operands
//   ser_a, ser_b  serial operand bits, MSB-first, to comparator a/b
//   ser_rst       one-cycle clear pulse to comparator rst
//   ser_op        comparator output suppress (1 = flags hidden)
//   frame_done    one-cycle pulse when the frame is shifted and flushed
//   busy          high in CLR, SHIFT and FLUSH
module comparator_operand_serializer #(
  parameter int W     = 8,
  parameter int FLUSH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_rst,
  output logic         ser_op,
  output logic         frame_done,
  output logic         busy
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            ser_a_q, ser_a_d;
  logic            ser_b_q, ser_b_d;
  logic            ser_rst_q, ser_rst_d;
  logic            ser_op_q, ser_op_d;
  logic            frame_done_q, frame_done_d;

  logic            accept;
  logic            last_bit;
  logic            last_flush;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = ~in_ready;
  assign accept     = in_valid & in_ready;
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign last_flush = (flush_cnt_q == '0);

  assign ser_a      = ser_a_q;
  assign ser_b      = ser_b_q;
  assign ser_rst    = ser_rst_q;
  assign ser_op     = ser_op_q;
  assign frame_done = frame_done_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_CLR;
      S_CLR:                   state_d = S_SHIFT;
      S_SHIFT: if (last_bit)   state_d = S_FLUSH;
      S_FLUSH: if (last_flush) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Datapath: operand shift registers and the bit/flush counters.
  // The registers shift once per bit handed to the output flops, so the bit
  // for the next cycle is always sitting in the MSB. The first shift happens
  // in CLR, when the MSB is loaded into ser_a/ser_b for the first SHIFT cycle.
  always_comb begin
    sa_d        = sa_q;
    sb_d        = sb_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sa_d      = in_a;
          sb_d      = in_b;
          bit_cnt_d = '0;
        end
      end
      S_CLR: begin
        sa_d = sa_q << 1;
        sb_d = sb_q << 1;
      end
      S_SHIFT: begin
        if (last_bit) begin
          bit_cnt_d   = '0;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sa_d      = sa_q << 1;
          sb_d      = sb_q << 1;
        end
      end
      S_FLUSH: begin
        if (!last_flush) begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic: every serial output is registered, so each value here is
  // the one to present during the cycle that follows the coming edge.
  always_comb begin
    ser_a_d      = 1'b0;
    ser_b_d      = 1'b0;
    ser_rst_d    = 1'b0;
    ser_op_d     = ser_op_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ser_rst_d = 1'b1;
          ser_op_d  = 1'b1;
        end
      end
      S_CLR: begin
        ser_a_d  = sa_q[W-1];
        ser_b_d  = sb_q[W-1];
        ser_op_d = 1'b1;
      end
      S_SHIFT: begin
        // On the last bit cycle the lines fall to 0 0 for the flush.
        if (!last_bit) begin
          ser_a_d = sa_q[W-1];
          ser_b_d = sb_q[W-1];
        end
        ser_op_d = 1'b1;
      end
      S_FLUSH: begin
        if (last_flush) begin
          ser_op_d     = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          ser_op_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q         <= '0;
      sb_q         <= '0;
      bit_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      ser_a_q      <= 1'b0;
      ser_b_q      <= 1'b0;
      ser_rst_q    <= 1'b0;
      ser_op_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      bit_cnt_q    <= bit_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      ser_a_q      <= ser_a_d;
      ser_b_q      <= ser_b_d;
      ser_rst_q    <= ser_rst_d;
      ser_op_q     <= ser_op_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_comparator_operand_serializer.sv
// tb/tb_comparator_operand_serializer.sv - self-checking bench for comparator_operand_serializer
module tb_comparator_operand_serializer;

  localparam int FL = 2;

  logic       clk;
  logic       rst;

  logic       iv0, r0, sa0, sb0, srst0, sop0, fd0, busy0;
  logic [7:0] ia0, ib0;
  logic       iv1, r1, sa1, sb1, srst1, sop1, fd1, busy1;
  logic [0:0] ia1, ib1;

  int total;
  int bad;

  comparator_operand_serializer #(.W(8), .FLUSH(FL)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(r0), .in_a(ia0), .in_b(ib0),
    .ser_a(sa0), .ser_b(sb0), .ser_rst(srst0), .ser_op(sop0),
    .frame_done(fd0), .busy(busy0)
  );

  comparator_operand_serializer #(.W(1), .FLUSH(FL)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(r1), .in_a(ia1), .in_b(ib1),
    .ser_a(sa1), .ser_b(sb1), .ser_rst(srst1), .ser_op(sop1),
    .frame_done(fd1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Observed vector: {in_ready, busy, ser_a, ser_b, ser_rst, ser_op, frame_done}
  function automatic logic [6:0] obs(input bit sel);
    if (sel) return {r1, busy1, sa1, sb1, srst1, sop1, fd1};
    return {r0, busy0, sa0, sb0, srst0, sop0, fd0};
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      iv1 = v; ia1 = a[0]; ib1 = b[0];
    end else begin
      iv0 = v; ia0 = a; ib0 = b;
    end
  endtask

  // Waits (bounded) for in_ready, offers the pair, returns #1 after the accept edge.
  task automatic start_frame(input bit sel, input logic [7:0] a, input logic [7:0] b);
    logic [6:0] o;
    int n;
    n = 0;
    o = obs(sel);
    while (o[6] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      o = obs(sel);
      n++;
    end
    total++;
    if (o[6] !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait sel=%0d in_ready=%b required=1", sel, o[6]);
    end
    set_in(sel, 1'b1, a, b);
    @(posedge clk); #1;
  endtask

  // Reference timeline of one frame, offset t edges after the accept edge:
  // t=0 clear pulse, t=1..w bit w-t of each operand, then FL flush cycles,
  // then the frame_done/IDLE cycle. A tiny MSB-first comparator model is fed
  // the observed lines to confirm the resulting L/E/G outcome.
  task automatic check_frame(input bit sel, input int w, input logic [7:0] a, input logic [7:0] b,
                             input bit hold, input logic [7:0] na, input logic [7:0] nb);
    logic [6:0] o, e;
    logic [7:0] got_a, got_b, ra, rb;
    logic       ea, eb, last;
    int         cmp, exp_cmp, rst_pulses;
    got_a = '0; got_b = '0; cmp = 0; rst_pulses = 0;
    if (hold) begin
      set_in(sel, 1'b1, na, nb);
    end else begin
      ra = 8'($urandom); rb = 8'($urandom);
      set_in(sel, 1'b0, ra, rb);
    end
    for (int t = 0; t <= w + FL + 1; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      o = obs(sel);
      ea = 1'b0; eb = 1'b0;
      if (t >= 1 && t <= w) begin
        ea = a[w - t];
        eb = b[w - t];
      end
      last = (t == w + FL + 1);
      e = {last, !last, ea, eb, t == 0, t <= w + FL, last};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL frame_cycle sel=%0d t=%0d a=%h b=%h got=%b required=%b", sel, t, a, b, o, e);
      end
      if (o[2]) begin
        rst_pulses++;
        cmp = 0;
      end else if (cmp == 0) begin
        if (o[4] && !o[3]) cmp = 2;
        else if (!o[4] && o[3]) cmp = 1;
      end
      if (t >= 1 && t <= w) begin
        got_a = {got_a[6:0], o[4]};
        got_b = {got_b[6:0], o[3]};
      end
    end
    total++;
    if (got_a !== a || got_b !== b) begin
      bad++;
      $display("FAIL serial_bits a=%h b=%h got_a=%h got_b=%h", a, b, got_a, got_b);
    end
    total++;
    if (rst_pulses != 1) begin
      bad++;
      $display("FAIL rst_pulses got=%0d required=1", rst_pulses);
    end
    exp_cmp = (a > b) ? 2 : ((a < b) ? 1 : 0);
    total++;
    if (cmp != exp_cmp) begin
      bad++;
      $display("FAIL cmp_flags a=%h b=%h got=%0d required=%0d (0=E 1=L 2=G)", a, b, cmp, exp_cmp);
    end
  endtask

  task automatic test_reset;
    logic [6:0] o;
    rst = 1'b1;
    set_in(1'b0, 1'b1, 8'hAA, 8'h55);
    set_in(1'b1, 1'b1, 8'h01, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = obs(s[0]);
      total++;
      if (o !== 7'b1000010) begin
        bad++;
        $display("FAIL reset_state sel=%0d got=%b required=1000010", s, o);
      end
    end
    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    set_in(1'b1, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      o = obs(s[0]);
      total++;
      if (o !== 7'b1000010) begin
        bad++;
        $display("FAIL idle_after_reset sel=%0d got=%b required=1000010", s, o);
      end
    end
  endtask

  task automatic test_vectors;
    start_frame(1'b0, 8'hA5, 8'hA5);
    check_frame(1'b0, 8, 8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00);
    start_frame(1'b0, 8'h80, 8'h7F);
    check_frame(1'b0, 8, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00);
    start_frame(1'b0, 8'h00, 8'hFF);
    check_frame(1'b0, 8, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back;
    start_frame(1'b0, 8'h12, 8'h13);
    check_frame(1'b0, 8, 8'h12, 8'h13, 1'b1, 8'h55, 8'h55);
    @(posedge clk); #1;
    check_frame(1'b0, 8, 8'h55, 8'h55, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_mid_reset;
    logic [6:0] o;
    int         fd_seen;
    start_frame(1'b0, 8'hC3, 8'h5A);
    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    o = obs(1'b0);
    total++;
    if (o !== 7'b1000010) begin
      bad++;
      $display("FAIL mid_reset_state got=%b required=1000010", o);
    end
    fd_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      o = obs(1'b0);
      if (o[0] || o[5]) fd_seen++;
    end
    total++;
    if (fd_seen != 0) begin
      bad++;
      $display("FAIL mid_reset_no_done got=%0d cycles with frame_done/busy required=0", fd_seen);
    end
    start_frame(1'b0, 8'h3C, 8'h3C);
    check_frame(1'b0, 8, 8'h3C, 8'h3C, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_width_one;
    logic [7:0] a, b;
    start_frame(1'b1, 8'h01, 8'h00);
    check_frame(1'b1, 1, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(1, 0));
      b = 8'($urandom_range(1, 0));
      start_frame(1'b1, a, b);
      check_frame(1'b1, 1, a, b, 1'b0, 8'h00, 8'h00);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a : 8'($urandom);
      start_frame(1'b0, a, b);
      check_frame(1'b0, 8, a, b, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    iv0 = 1'b0; ia0 = '0; ib0 = '0;
    iv1 = 1'b0; ia1 = '0; ib1 = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    test_width_one();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_operand_serializer.md
# comparator_operand_serializer

Transmit side of the bit-serial unsigned compare path. The block accepts two W-bit unsigned operands over a valid/ready handshake and clears the downstream sequential comparator. It then shifts both operands out MSB-first, one bit pair per cycle, and drives the comparator's op (output-suppress) line so the L/E/G flags only appear once the whole frame has settled. It sits between the operand source and the sequential comparator, and owns that comparator's rst and op inputs.

## Interface
- W, 8: operand width in bits; legal W >= 1.
- FLUSH, 2: idle bit-cycles after the last bit, covering the comparator's internal pipeline; legal FLUSH >= 1.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair (high only in IDLE).
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- ser_a  out  1  serial bit of A, MSB-first; drives comparator a.
- ser_b  out  1  serial bit of B, MSB-first; drives comparator b.
- ser_rst  out  1  drives comparator rst; one-cycle pulse per frame.
- ser_op  out  1  drives comparator op; 1 suppresses its flags, 0 lets the flags display.
- frame_done  out  1  one-cycle pulse when the frame is fully shifted and flushed.
- busy  out  1  high in CLR, SHIFT and FLUSH.

## Operation
- State machine: IDLE -> CLR -> SHIFT -> FLUSH -> IDLE.
- Transitions:
  - IDLE -> CLR on in_valid & in_ready.
  - CLR -> SHIFT unconditionally after 1 cycle.
  - SHIFT -> FLUSH after W cycles.
  - FLUSH -> IDLE after FLUSH cycles.
- Accept: in_a and in_b are captured into internal W-bit shift registers sa and sb. Input changes after the accept edge have no effect.
- CLR: ser_rst=1, ser_op=1, ser_a=ser_b=0.
- SHIFT:
  - ser_a = sa[W-1], ser_b = sb[W-1].
  - Both registers shift left by 1 each cycle, zero-filled.
  - A mod-W bit counter counts 0..W-1; SHIFT exits when the count is W-1.
  - ser_op=1, ser_rst=0.
- FLUSH: ser_a=ser_b=0 (equal bits, so the comparator state is unchanged), ser_op=1; a down-counter runs from FLUSH-1 to 0.
- Exit to IDLE: frame_done=1 for the first IDLE cycle, and ser_op is cleared to 0.
- IDLE: ser_op holds 0 so the comparator flags stay displayed until the next accept. ser_a, ser_b and ser_rst are 0.
- All outputs are registered. No combinational path exists from in_* to ser_*; in_ready is decoded from the state register.
- in_valid while busy: ignored. The upstream source must hold its data until in_ready.
- Reset mid-frame: the state returns to IDLE, the frame is discarded and no frame_done is issued.
- Reset values:
  - in_ready=1, busy=0.
  - ser_a=0, ser_b=0, ser_rst=0.
  - ser_op=1 (flags suppressed until the first completed frame).
  - frame_done=0.
  - Internal counters and shift registers are 0.
- W=1: SHIFT lasts exactly 1 cycle; the counter logic must not underflow.

## Timing
- Accept at edge k (in_valid & in_ready sampled high).
- Cycle k..k+1: ser_rst=1, busy=1, in_ready=0.
- Cycles after edges k+1 .. k+W: bit i = W-1-(edge index - (k+1)) is presented on ser_a/ser_b.
- Cycles after edges k+W+1 .. k+W+FLUSH: flush.
- After edge k+W+FLUSH+1:
  - state is IDLE, frame_done=1 for 1 cycle, ser_op=0, in_ready=1.
  - The comparator flags are valid after the following edge.
- Frame period: W+FLUSH+2 cycles minimum, including 1 IDLE cycle. Back-to-back accept is allowed in the frame_done cycle.
- rst has priority over every other event at the same edge, including an accept.

## Test plan
- W=8, A=0xA5, B=0xA5 -> ser_a = ser_b = 1,0,1,0,0,1,0,1; frame_done at accept+11 edges; attached comparator gives E=1.
- W=8, A=0x80, B=0x7F -> first bit pair (1,0); comparator gives G=1; ser_op stays 1 until frame_done, then 0.
- W=8, A=0x00, B=0xFF -> ser_a all 0, ser_b all 1; comparator gives L=1; ser_rst pulses exactly once, in the cycle after accept.
- in_valid held high continuously with a 2-frame sequence (0x12 vs 0x13, then 0x55 vs 0x55) -> second accept in the frame_done cycle; second frame E=1, not contaminated by the prior L; in_a changed mid-frame has no effect.
- rst asserted at the 4th SHIFT cycle -> next edge: in_ready=1, ser_op=1, ser_a=0, ser_b=0, no frame_done; a subsequent frame 0x3C vs 0x3C completes normally with E=1.
- W=1, A=1, B=0 -> SHIFT lasts 1 cycle; frame_done at accept+4 edges; comparator gives G=1.
